// File: rtl/vend_ctrl.sv
// Two-item vending transaction controller: coin credit, dispense handshake,
// then half-yuan change payout one coin at a time through the hopper.
module vend_ctrl #(
   parameter int PRICE_A    = 4,
   parameter int PRICE_B    = 3,
   parameter int CREDIT_MAX = 8,
   parameter int TIMEOUT    = 1000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pi_money_half,
   input  logic       pi_money_one,
   input  logic [1:0] pi_sel,
   input  logic       pi_cancel,
   input  logic       pi_disp_done,
   input  logic       pi_coin_ack,
   output logic       po_disp_req,
   output logic       po_disp_item,
   output logic       po_coin_req,
   output logic       po_coin_reject,
   output logic [3:0] po_credit,
   output logic       po_busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] VEND   = 2'd1;
   localparam logic [1:0] CHANGE = 2'd2;

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
   localparam logic [4:0] MAX5 = 5'(CREDIT_MAX);
   localparam logic [3:0] PA4  = 4'(PRICE_A);
   localparam logic [3:0] PB4  = 4'(PRICE_B);

   logic [1:0]    state, state_n;
   logic [3:0]    credit, credit_n;
   logic [CW-1:0] tcnt, tcnt_n;
   logic          item, item_n;
   logic          reject, reject_n;
   logic          disp_req, coin_req, busy;

   logic          coin_any;
   logic          coin_both;
   logic [4:0]    coin_sum;
   logic          sel_ok;
   logic [3:0]    price;

   assign coin_any  = pi_money_half | pi_money_one;
   assign coin_both = pi_money_half & pi_money_one;
   assign coin_sum  = {1'b0, credit} + (pi_money_one ? 5'd2 : 5'd1);
   assign sel_ok    = (pi_sel == 2'b01) || (pi_sel == 2'b10);
   assign price     = (pi_sel == 2'b10) ? PB4 : PA4;

   always_comb begin
      state_n  = state;
      credit_n = credit;
      tcnt_n   = tcnt;
      item_n   = item;
      reject_n = 1'b0;
      case (state)
         IDLE: begin
            if (pi_cancel) begin
               reject_n = coin_any;
               tcnt_n   = '0;
               if (credit != 4'd0)
                  state_n = CHANGE;
            end else if (coin_any) begin
               // a rejected coin neither restarts nor advances the idle timer
               if (coin_both || coin_sum > MAX5) begin
                  reject_n = 1'b1;
               end else begin
                  credit_n = coin_sum[3:0];
                  tcnt_n   = '0;
               end
            end else if (sel_ok) begin
               tcnt_n = '0;
               if (credit >= price) begin
                  credit_n = credit - price;
                  item_n   = pi_sel[1];
                  state_n  = VEND;
               end
            end else if (credit != 4'd0) begin
               if (tcnt == T_LAST) begin
                  state_n = CHANGE;
                  tcnt_n  = '0;
               end else begin
                  tcnt_n = tcnt + 1'b1;
               end
            end
         end
         VEND: begin
            reject_n = coin_any;
            tcnt_n   = '0;
            if (pi_disp_done)
               state_n = (credit != 4'd0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_n = coin_any;
            tcnt_n   = '0;
            if (pi_coin_ack && credit != 4'd0) begin
               credit_n = credit - 4'd1;
               if (credit == 4'd1)
                  state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            tcnt_n  = '0;
         end
      endcase
      if (credit_n == 4'd0)
         tcnt_n = '0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         credit   <= 4'd0;
         tcnt     <= '0;
         item     <= 1'b0;
         reject   <= 1'b0;
         disp_req <= 1'b0;
         coin_req <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         credit   <= credit_n;
         tcnt     <= tcnt_n;
         item     <= item_n;
         reject   <= reject_n;
         disp_req <= (state_n == VEND);
         coin_req <= (state_n == CHANGE);
         busy     <= (state_n != IDLE);
      end
   end

   assign po_disp_req    = disp_req;
   assign po_disp_item   = item;
   assign po_coin_req    = coin_req;
   assign po_coin_reject = reject;
   assign po_credit      = credit;
   assign po_busy        = busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a transaction-level model predicts outputs,
// a monitor compares them one cycle after each stimulus.
module tb_vend_ctrl;

   localparam int PA  = 4;
   localparam int PB  = 3;
   localparam int MAXC = 8;
   localparam int TO  = 10;

   typedef struct packed {
      logic       disp_req;
      logic       item;
      logic       coin_req;
      logic       reject;
      logic [3:0] credit;
      logic       busy;
   } out_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       pi_money_half = 1'b0;
   logic       pi_money_one = 1'b0;
   logic [1:0] pi_sel = 2'b00;
   logic       pi_cancel = 1'b0;
   logic       pi_disp_done = 1'b0;
   logic       pi_coin_ack = 1'b0;
   logic       po_disp_req;
   logic       po_disp_item;
   logic       po_coin_req;
   logic       po_coin_reject;
   logic [3:0] po_credit;
   logic       po_busy;

   vend_ctrl #(
      .PRICE_A(PA), .PRICE_B(PB), .CREDIT_MAX(MAXC), .TIMEOUT(TO)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .pi_money_half(pi_money_half),
      .pi_money_one(pi_money_one),
      .pi_sel(pi_sel),
      .pi_cancel(pi_cancel),
      .pi_disp_done(pi_disp_done),
      .pi_coin_ack(pi_coin_ack),
      .po_disp_req(po_disp_req),
      .po_disp_item(po_disp_item),
      .po_coin_req(po_coin_req),
      .po_coin_reject(po_coin_reject),
      .po_credit(po_credit),
      .po_busy(po_busy)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors = 0;
   int miscompares = 0;
   out_t expq[$];

   // model: mode 0 = waiting for coins, 1 = dispensing, 2 = paying change
   int m_mode = 0;
   int m_credit = 0;
   int m_idle = 0;
   int m_item = 0;

   function automatic out_t actual();
      out_t a;
      a.disp_req = po_disp_req;
      a.item     = po_disp_item;
      a.coin_req = po_coin_req;
      a.reject   = po_coin_reject;
      a.credit   = po_credit;
      a.busy     = po_busy;
      return a;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = actual();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got req=%b item=%b creq=%b rej=%b cr=%0d busy=%b, want req=%b item=%b creq=%b rej=%b cr=%0d busy=%b",
                  name, act.disp_req, act.item, act.coin_req, act.reject, act.credit, act.busy,
                  exp.disp_req, exp.item, exp.coin_req, exp.reject, exp.credit, exp.busy);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_credit = 0;
      m_idle = 0;
      m_item = 0;
   endtask

   task automatic step(input bit half, input bit one, input bit [1:0] sel,
                       input bit cancel, input bit done, input bit ack);
      bit   rej;
      int   val;
      int   price;
      out_t e;
      @(negedge sys_clk);
      pi_money_half = half;
      pi_money_one  = one;
      pi_sel        = sel;
      pi_cancel     = cancel;
      pi_disp_done  = done;
      pi_coin_ack   = ack;
      rej = 1'b0;
      if (m_mode == 0) begin
         val   = one ? 2 : 1;
         price = (sel == 2'b10) ? PB : PA;
         if (cancel) begin
            rej = half | one;
            m_idle = 0;
            if (m_credit > 0) m_mode = 2;
         end else if (half || one) begin
            if ((half && one) || m_credit + val > MAXC) rej = 1'b1;
            else begin
               m_credit += val;
               m_idle = 0;
            end
         end else if (sel == 2'b01 || sel == 2'b10) begin
            m_idle = 0;
            if (m_credit >= price) begin
               m_credit -= price;
               m_item = (sel == 2'b10) ? 1 : 0;
               m_mode = 1;
            end
         end else if (m_credit > 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_mode = 2;
               m_idle = 0;
            end
         end
      end else if (m_mode == 1) begin
         rej = half | one;
         if (done) m_mode = (m_credit > 0) ? 2 : 0;
      end else begin
         rej = half | one;
         if (ack && m_credit > 0) begin
            m_credit--;
            if (m_credit == 0) m_mode = 0;
         end
      end
      if (m_credit == 0 || m_mode != 0) m_idle = 0;
      e.disp_req = (m_mode == 1);
      e.item     = m_item[0];
      e.coin_req = (m_mode == 2);
      e.reject   = rej;
      e.credit   = 4'(m_credit);
      e.busy     = (m_mode != 0);
      expq.push_back(e);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, 0);
   endtask

   always @(posedge sys_clk) begin
      #1;
      if (expq.size() > 0) check("scoreboard", expq.pop_front());
   end

   initial begin
      out_t zero;
      zero = '0;
      #12;
      check("reset_state", zero);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // buy A with exact credit
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 0, 2'b01, 0, 0, 0);
      idle_n(2);
      step(0, 0, 2'b00, 0, 1, 0);
      idle_n(1);

      // buy B with change, one ack stall
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 0, 2'b10, 0, 0, 0);
      step(1, 0, 2'b00, 0, 0, 0);
      step(0, 0, 2'b00, 0, 1, 0);
      step(0, 0, 2'b00, 0, 0, 1);
      step(0, 0, 2'b00, 0, 0, 0);
      step(0, 0, 2'b00, 0, 0, 1);
      step(0, 0, 2'b00, 0, 0, 1);
      idle_n(1);

      // overflow and double-coin rejects, then refund
      for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 0, 0, 0);
      step(1, 0, 2'b00, 0, 0, 0);
      step(1, 1, 2'b00, 0, 0, 0);
      step(0, 0, 2'b00, 1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 0, 0, 1);

      // insufficient selection, cancel with coin
      step(0, 1, 2'b00, 0, 0, 0);
      step(0, 0, 2'b01, 0, 0, 0);
      step(0, 1, 2'b00, 1, 0, 0);
      step(0, 0, 2'b00, 0, 0, 1);
      step(0, 0, 2'b00, 0, 0, 1);

      // timeout, and restart by a second coin
      step(1, 0, 2'b00, 0, 0, 0);
      idle_n(11);
      step(0, 0, 2'b00, 0, 0, 1);
      step(1, 0, 2'b00, 0, 0, 0);
      idle_n(4);
      step(1, 0, 2'b00, 0, 0, 0);
      idle_n(11);
      step(0, 0, 2'b00, 0, 0, 1);
      step(0, 0, 2'b00, 0, 0, 1);

      // async reset mid-change with credit 3
      step(0, 1, 2'b00, 0, 0, 0);
      step(1, 0, 2'b00, 0, 0, 0);
      step(0, 0, 2'b00, 1, 0, 0);
      step(0, 0, 2'b00, 0, 0, 0);
      @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_reset", zero);
      model_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit       h, o, c, d, a;
         bit [1:0] s;
         h = ($urandom_range(99) < 15);
         o = ($urandom_range(99) < 15);
         s = ($urandom_range(99) < 25) ? 2'($urandom_range(3)) : 2'b00;
         c = ($urandom_range(99) < 4);
         d = ($urandom_range(99) < 30);
         a = ($urandom_range(99) < 40);
         step(h, o, s, c, d, a);
      end

      for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge sys_clk);
      #3;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction controller for a two-item vending unit. Accumulates coin credit in half-yuan units and accepts item selection. Sequences the dispense mechanism through a request/done handshake, then pays change one half-yuan coin at a time through a hopper request/ack handshake. Sits between the coin/button front end and the dispenser and hopper drivers.

Parameters:
PRICE_A, 4, price of item A in half-yuan units (2.0 yuan)
PRICE_B, 3, price of item B in half-yuan units (1.5 yuan)
CREDIT_MAX, 8, maximum credit held (4.0 yuan); must be <= 15
TIMEOUT, 1000, idle cycles with nonzero credit before automatic refund; must be >= 2

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  reset, asynchronous, active-low
pi_money_half  in  1  one-cycle pulse: 0.5-yuan coin inserted
pi_money_one  in  1  one-cycle pulse: 1-yuan coin inserted
pi_sel  in  2  one-cycle pulse: 2'b01 selects item A, 2'b10 selects item B; 00/11 mean no selection
pi_cancel  in  1  one-cycle pulse: refund request
pi_disp_done  in  1  dispenser finished current item
pi_coin_ack  in  1  hopper released one half-yuan coin
po_disp_req  out  1  dispense request, level held until done
po_disp_item  out  1  item being dispensed: 0 = A, 1 = B
po_coin_req  out  1  change request, level held while change is owed
po_coin_reject  out  1  one-cycle pulse: inserted coin returned unaccepted
po_credit  out  4  current credit, in half-yuan units
po_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset value of every output is 0. State is IDLE. Credit is 0. Timeout counter is 0.
- All outputs are registered. Every response appears on the clock edge after the triggering input is sampled.
- States: IDLE, VEND, CHANGE. The state register and its outputs may use any encoding.

IDLE, per-cycle priority:
1. pi_cancel:
   - Credit > 0 -> CHANGE. Credit = 0 -> stay in IDLE.
   - A coin in the same cycle is rejected. A selection in the same cycle is ignored.
2. Any coin pulse, evaluated before selection:
   - Both coin pulses in one cycle -> po_coin_reject pulses and credit is unchanged.
   - credit + value > CREDIT_MAX -> reject.
   - Otherwise credit += 1 (half) or += 2 (one).
   - A selection in the same cycle is ignored.
3. Valid pi_sel with credit >= price:
   - credit -= price.
   - po_disp_item is latched.
   - po_disp_req goes high.
   - State -> VEND.
   - Selection with insufficient credit, or pi_sel = 00/11, is ignored; state stays IDLE.
4. Timeout:
   - The counter clears on reset, on any accepted coin, on any cancel or selection event, and whenever credit = 0.
   - While in IDLE with credit > 0 and no event, the counter increments.
   - When the counter reaches TIMEOUT-1, the state goes to CHANGE on the next edge. Refund starts exactly TIMEOUT idle cycles after the last event.

VEND:
- po_disp_req stays high until pi_disp_done is sampled high.
- On that edge po_disp_req drops. Credit > 0 -> CHANGE; otherwise -> IDLE.
- Coins are rejected (po_coin_reject pulses). Selection and cancel are ignored.
- pi_disp_done outside VEND is ignored.

CHANGE:
- po_coin_req is high throughout.
- On each edge with pi_coin_ack high, credit -= 1.
- On the ack that takes credit from 1 to 0, po_coin_req drops on the same edge and state -> IDLE.
- Coins are rejected. Selection and cancel are ignored.
- pi_coin_ack outside CHANGE is ignored and credit never underflows.

Other rules:
- Credit is an unsigned 4-bit value and never exceeds CREDIT_MAX.
- po_coin_reject is high for exactly one cycle per rejected cycle and is otherwise 0.
- Reset asserted mid-transaction clears everything immediately (asynchronously). Credit is lost and no handshake completes.

Test Plan:
- Insert one, one, then sel = 01 -> po_credit 2, 4. Next edge: po_disp_req = 1, po_disp_item = 0, po_credit = 0. Done after 3 cycles -> po_disp_req = 0, state IDLE, po_coin_req never asserts.
- Insert one, one, one, then sel = 10 -> credit 6, then 3 and VEND. On done -> CHANGE with po_coin_req = 1. Three acks (one with a stall cycle) -> credit 2, 1, 0; po_coin_req drops on the third ack; po_busy = 0.
- With credit 8, insert half -> po_coin_reject pulses 1 cycle, credit stays 8. pi_money_half and pi_money_one together -> reject, credit unchanged. Coin during VEND -> reject.
- Credit 2, sel = 01 -> ignored, state IDLE. Cancel with a coin in the same cycle -> coin rejected, CHANGE, two acks return 2, IDLE.
- TIMEOUT = 10: insert half then idle -> CHANGE entered exactly 10 cycles later. A second coin at cycle 5 restarts the count.
- Assert sys_rst_n low mid-CHANGE with credit 3 -> all outputs 0 immediately. After release, acks are ignored and state is IDLE.
